// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter.
// Imported by the arbiter top and its grant picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    // Sized for the largest legal MAX_STREAK (15).
    localparam int MAX_STREAK_LIM = 15;
    localparam int STREAK_W = $clog2(MAX_STREAK_LIM + 1);

endpackage

// File: rtl/arb_pick.sv
// Combinational grant picker: data first, fetch when the
// data streak has reached its limit. gnt_o[0]=fetch, [1]=data.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic       if_req_i,
    input  logic       d_req_i,
    input  logic       streak_max_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (d_req_i && !(if_req_i && streak_max_i)) begin
            gnt_o = 2'b10;
        end else if (if_req_i) begin
            gnt_o = 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data.
// One transaction in flight; data priority, bounded streak.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    arb_state_t          state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                we_q, we_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       wdata_q, wdata_d;
    logic [DW-1:0]       if_rdata_q, if_rdata_d;
    logic [DW-1:0]       d_rdata_q, d_rdata_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic       at_max;
    logic       gnt_en;
    logic [1:0] pick;

    assign at_max = (streak_q == STREAK_W'(MAX_STREAK));
    // Grants are masked during reset so every output reads 0.
    assign gnt_en = (state_q == IDLE) && !rst;

    arb_pick u_pick (
        .if_req_i     (if_req),
        .d_req_i      (d_req),
        .streak_max_i (at_max),
        .gnt_o        (pick)
    );

    assign if_gnt = gnt_en & pick[0];
    assign d_gnt  = gnt_en & pick[1];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        streak_d   = streak_q;
        unique case (state_q)
            IDLE: begin
                if (if_gnt) begin
                    state_d  = WAIT;
                    owner_d  = OWN_IF;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    streak_d = '0;
                end else if (d_gnt) begin
                    state_d  = WAIT;
                    owner_d  = OWN_D;
                    we_d     = d_we;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (!at_max) begin
                        streak_d = streak_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (m_ack) begin
                    state_d = RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = m_rdata;
                    end else begin
                        d_rdata_d = we_q ? '0 : m_rdata;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            streak_q   <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            streak_q   <= streak_d;
        end
    end

    // Memory side is the captured command gated by the WAIT state.
    assign m_req   = (state_q == WAIT);
    assign m_we    = m_req & we_q;
    assign m_addr  = m_req ? addr_q : '0;
    assign m_wdata = m_req ? wdata_q : '0;

    assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
    assign d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule
